// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester arbitrated adder: state encoding,
// default widths and the round-robin winner selection.
package adder_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  // A lone requester always wins; on a tie the one that did not win last time goes.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

endpackage

// File: rtl/adder_arbiter_add16.sv
// WIDTH-bit ripple-carry adder with carry-out; purely combinational.
module add16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic c;

  always_comb begin
    c     = 1'b0;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter between two requesters sharing one adder; each granted
// operation runs IDLE -> EXEC -> DONE and presents its sum for one cycle.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] OUTPUT_DATA,
  output logic             CARRY,
  output logic             VALID,
  output logic             RES_ID,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_COUNT
);

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               res_id_q, res_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;

  add16 #(
    .WIDTH(WIDTH)
  ) u_add (
    .a_i    (a_q),
    .b_i    (b_q),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    res_id_d = res_id_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          win_d   = pick_winner(REQ0, REQ1, last_q);
          a_d     = win_d ? A1 : A0;
          b_d     = win_d ? B1 : B0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d    = add_sum;
        carry_d  = add_carry;
        res_id_d = win_q;
        state_d  = DONE;
      end
      DONE: begin
        // Fairness pointer only moves once the result has actually been delivered.
        last_d  = win_q;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      res_id_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      res_id_q <= res_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // The grant pulse is the EXEC cycle, so only one requester can ever see it.
  assign GNT0        = (state_q == EXEC) && !win_q;
  assign GNT1        = (state_q == EXEC) && win_q;
  assign VALID       = (state_q == DONE);
  assign BUSY        = (state_q != IDLE);
  assign OUTPUT_DATA = sum_q;
  assign CARRY       = carry_q;
  assign RES_ID      = res_id_q;
  assign OP_COUNT    = cnt_q;

endmodule
